// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic MAC array and its job sequencer.
package systolic_pkg;

   localparam int unsigned width_lp          = 8;
   localparam int unsigned array_width_lp    = 2;
   localparam int unsigned array_height_lp   = 2;
   localparam int unsigned compute_cycles_lp = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      DRAIN,
      DONE
   } state_e;

   // Bits needed to hold every value from 0 up to and including max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/systolic_sequencer_seq_counter.sv
// Up-counter with synchronous clear, increment enable and a compare against a fixed terminal value.
module seq_counter #(
   parameter int unsigned width_p    = 4,
   parameter int unsigned terminal_p = 0
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic clear_i,
   input  logic incr_i,
   output logic last_o
);

   localparam logic [width_p-1:0] terminal_lp = width_p'(terminal_p);

   logic [width_p-1:0] count_q;

   always_ff @(posedge clk_i) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n_i)   count_q <= '0;
      else if (clear_i) count_q <= '0;
      else if (incr_i)  count_q <= count_q + width_p'(1);
   end

   assign last_o = (count_q == terminal_lp);

endmodule

// File: rtl/systolic_sequencer.sv
// Job controller for the systolic MAC array: load operands, compute, drain results, signal done.
// Optional SYSTOLIC_SEQ_FLUSH_EN pulses array_flush_o in DONE and in the first cycle after reset.
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter int unsigned width_p          = width_lp,
   parameter int unsigned array_width_p    = array_width_lp,
   parameter int unsigned array_height_p   = array_height_lp,
   parameter int unsigned compute_cycles_p = compute_cycles_lp
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               start_i,
   input  logic               valid_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               array_en_o,
   output logic               array_flush_o,
   output logic               array_valid_o,
   output logic [width_p-1:0] array_data_o,
   input  logic               array_ready_i,
   input  logic               array_valid_i,
   input  logic [width_p-1:0] array_data_i,
   output logic               array_yumi_o,
   output logic               fifo_valid_o,
   output logic [width_p-1:0] fifo_data_o,
   input  logic               fifo_ready_i,
   output logic               busy_o,
   output logic               done_o
);

   localparam int unsigned num_macs_lp = array_width_p * array_height_p;
   localparam int unsigned num_ops_lp  = 2 * num_macs_lp;

   state_e state_q;
   logic   clear_cnt;
   logic   op_fire;
   logic   op_last;
   logic   cycle_fire;
   logic   cycle_last;
   logic   res_last;

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      array_en_o    = 1'b0;
      ready_o       = 1'b0;
      array_valid_o = 1'b0;
      fifo_valid_o  = 1'b0;
      array_yumi_o  = 1'b0;
      case (state_q)
         LOAD: begin
            array_en_o    = 1'b1;
            ready_o       = array_ready_i;
            array_valid_o = valid_i;
         end
         COMPUTE: array_en_o = 1'b1;
         DRAIN: begin
            array_en_o   = 1'b1;
            fifo_valid_o = array_valid_i;
            array_yumi_o = array_valid_i & fifo_ready_i;
         end
         default: ;
      endcase
   end

   assign array_data_o = data_i;
   assign fifo_data_o  = array_data_i;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);

   // Counters sit at zero throughout IDLE, so a job always starts from a clean count.
   assign clear_cnt  = (state_q == IDLE);
   assign op_fire    = valid_i & ready_o;
   assign cycle_fire = (state_q == COMPUTE);

   seq_counter #(.width_p(cnt_width(num_ops_lp)), .terminal_p(num_ops_lp - 1)) op_cnt (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_cnt), .incr_i(op_fire), .last_o(op_last)
   );

   seq_counter #(.width_p(cnt_width(compute_cycles_p)), .terminal_p(compute_cycles_p - 1)) cycle_cnt (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_cnt), .incr_i(cycle_fire), .last_o(cycle_last)
   );

   seq_counter #(.width_p(cnt_width(num_macs_lp)), .terminal_p(num_macs_lp - 1)) res_cnt (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_cnt), .incr_i(array_yumi_o), .last_o(res_last)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_i) state_q <= LOAD;
            LOAD:    if (op_fire && op_last) state_q <= COMPUTE;
            COMPUTE: if (cycle_last) state_q <= DRAIN;
            DRAIN:   if (array_yumi_o && res_last) state_q <= DONE;
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SYSTOLIC_SEQ_FLUSH_EN
   logic post_reset_q;

   always_ff @(posedge clk_i) begin
      post_reset_q <= !reset_n_i;
   end

   assign array_flush_o = (state_q == DONE) | post_reset_q;
`else
   assign array_flush_o = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized bench for systolic_sequencer checked cycle by cycle against a count-based job model.
module tb_systolic_sequencer;

   localparam int W        = 8;
   localparam int NUM_MACS = 4;
   localparam int NUM_OPS  = 2 * NUM_MACS;
   localparam int CC       = 4;
   localparam int BUDGET   = 300;

   logic         clk_i;
   logic         reset_n_i;
   logic         start_i;
   logic         valid_i;
   logic [W-1:0] data_i;
   logic         ready_o;
   logic         array_en_o;
   logic         array_flush_o;
   logic         array_valid_o;
   logic [W-1:0] array_data_o;
   logic         array_ready_i;
   logic         array_valid_i;
   logic [W-1:0] array_data_i;
   logic         array_yumi_o;
   logic         fifo_valid_o;
   logic [W-1:0] fifo_data_o;
   logic         fifo_ready_i;
   logic         busy_o;
   logic         done_o;

   systolic_sequencer #(
      .width_p(W), .array_width_p(2), .array_height_p(2), .compute_cycles_p(CC)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
      .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
      .array_en_o(array_en_o), .array_flush_o(array_flush_o),
      .array_valid_o(array_valid_o), .array_data_o(array_data_o),
      .array_ready_i(array_ready_i), .array_valid_i(array_valid_i),
      .array_data_i(array_data_i), .array_yumi_o(array_yumi_o),
      .fifo_valid_o(fifo_valid_o), .fifo_data_o(fifo_data_o),
      .fifo_ready_i(fifo_ready_i), .busy_o(busy_o), .done_o(done_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef enum int {P_IDLE, P_LOAD, P_COMPUTE, P_DRAIN, P_DONE} phase_e;

   int n_checks = 0;
   int n_fail   = 0;

   // Job model: progress is just how many operands, compute cycles and results have happened.
   bit m_active     = 1'b0;
   bit m_post_reset = 1'b1;
   int m_ops        = 0;
   int m_cyc        = 0;
   int m_res        = 0;

   logic [W-1:0] op_q[$];
   logic [W-1:0] res_q[$];
   logic [W-1:0] got_ops[$];
   logic [W-1:0] got_res[$];
   int op_idx;
   int res_idx;

   function automatic phase_e cur_phase();
      if (!m_active)         return P_IDLE;
      if (m_ops < NUM_OPS)   return P_LOAD;
      if (m_cyc < CC)        return P_COMPUTE;
      if (m_res < NUM_MACS)  return P_DRAIN;
      return P_DONE;
   endfunction

   function automatic bit chance(input int pct);
      return $urandom_range(99) < pct;
   endfunction

   // Samples mid-cycle, forms expected and observed output vectors, then advances one clock.
   task automatic step(output logic [23:0] exp_v, output logic [23:0] obs_v);
      phase_e ph;
      bit     flush;
      #4;
      ph = cur_phase();
`ifdef SYSTOLIC_SEQ_FLUSH_EN
      flush = (ph == P_DONE) || m_post_reset;
`else
      flush = 1'b0;
`endif
      exp_v = {ph != P_IDLE,
               ph == P_LOAD || ph == P_COMPUTE || ph == P_DRAIN,
               ph == P_LOAD && array_ready_i,
               ph == P_LOAD && valid_i,
               ph == P_DRAIN && array_valid_i,
               ph == P_DRAIN && array_valid_i && fifo_ready_i,
               ph == P_DONE,
               flush, data_i, array_data_i};
      obs_v = {busy_o, array_en_o, ready_o, array_valid_o, fifo_valid_o,
               array_yumi_o, done_o, array_flush_o, array_data_o, fifo_data_o};
      if (array_valid_o && array_ready_i) got_ops.push_back(array_data_o);
      if (fifo_valid_o && fifo_ready_i)   got_res.push_back(fifo_data_o);
      if (valid_i && ready_o) op_idx++;
      if (array_yumi_o)       res_idx++;
      if (!reset_n_i) begin
         m_active     = 1'b0;
         m_post_reset = 1'b1;
      end else begin
         m_post_reset = 1'b0;
         case (ph)
            P_IDLE:    if (start_i) begin m_active = 1'b1; m_ops = 0; m_cyc = 0; m_res = 0; end
            P_LOAD:    if (valid_i && array_ready_i) m_ops++;
            P_COMPUTE: m_cyc++;
            P_DRAIN:   if (array_valid_i && fifo_ready_i) m_res++;
            P_DONE:    m_active = 1'b0;
            default:   ;
         endcase
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_job(input string name, input bit nominal,
                          input int pv, input int pa, input int pf, input int pr,
                          input int a_stall_at, input int a_stall_len,
                          input int f_stall_at, input int f_stall_len,
                          input int abort_at, input bit hold_start,
                          output int job_cycles, output int dones);
      logic [23:0] e, o;
      int  cyc, abort_cyc, a_left, f_left;
      bit  finished, aborted;
      op_q.delete(); res_q.delete(); got_ops.delete(); got_res.delete();
      for (int i = 0; i < NUM_OPS; i++)  op_q.push_back(nominal ? W'(i + 1) : W'($urandom));
      for (int i = 0; i < NUM_MACS; i++) res_q.push_back(nominal ? W'(16 * (i + 1)) : W'($urandom));
      op_idx = 0; res_idx = 0; cyc = 0; abort_cyc = 0; job_cycles = -1; dones = 0;
      a_left = a_stall_len; f_left = f_stall_len; finished = 1'b0; aborted = 1'b0;
      while (!finished && cyc < BUDGET) begin
         start_i   = (cyc == 0) ? 1'b1 : hold_start;
         reset_n_i = 1'b1;
         if (abort_at >= 0 && !aborted && cur_phase() == P_LOAD && op_idx == abort_at) begin
            reset_n_i = 1'b0;
            aborted   = 1'b1;
            abort_cyc = cyc;
         end
         valid_i = (op_idx < NUM_OPS) && chance(pv);
         data_i  = (op_idx < NUM_OPS) ? op_q[op_idx] : W'($urandom);
         if (a_stall_at >= 0 && cur_phase() == P_LOAD && op_idx >= a_stall_at && a_left > 0) begin
            array_ready_i = 1'b0;
            a_left--;
         end else begin
            array_ready_i = chance(pa);
         end
         if (f_stall_at >= 0 && cur_phase() == P_DRAIN && res_idx >= f_stall_at && f_left > 0) begin
            fifo_ready_i = 1'b0;
            f_left--;
         end else begin
            fifo_ready_i = chance(pf);
         end
         array_valid_i = (res_idx < NUM_MACS) && chance(pr);
         array_data_i  = (res_idx < NUM_MACS) ? res_q[res_idx] : W'($urandom);
         if (cur_phase() == P_DONE) begin
            job_cycles = cyc;
            finished   = 1'b1;
         end
         step(e, o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL %s outputs cycle %0d: dut=%h expected=%h", name, cyc, o, e);
         end
         if (o[17]) dones++;
         if (aborted && cyc >= abort_cyc + 3) finished = 1'b1;
         cyc++;
      end
      start_i = 1'b0;
      n_checks++;
      if (!finished) begin
         n_fail++;
         $display("FAIL %s timeout: ran %0d cycles, required completion within %0d", name, cyc, BUDGET);
      end
      if (!aborted) begin
         n_checks++;
         if (got_ops.size() != NUM_OPS || got_res.size() != NUM_MACS) begin
            n_fail++;
            $display("FAIL %s transfer count: ops=%0d results=%0d, required %0d and %0d",
                     name, got_ops.size(), got_res.size(), NUM_OPS, NUM_MACS);
         end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
               n_checks++;
               if (got_ops[i] !== op_q[i]) begin
                  n_fail++;
                  $display("FAIL %s operand %0d: got %h, required %h", name, i, got_ops[i], op_q[i]);
               end
            end
            for (int i = 0; i < NUM_MACS; i++) begin
               n_checks++;
               if (got_res[i] !== res_q[i]) begin
                  n_fail++;
                  $display("FAIL %s result %0d: got %h, required %h", name, i, got_res[i], res_q[i]);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [23:0] e, o;
      for (int i = 0; i < 3; i++) begin
         reset_n_i = 1'b0; start_i = 1'b1; data_i = '0; array_data_i = '0;
         valid_i = chance(50); array_ready_i = chance(50);
         array_valid_i = chance(50); fifo_ready_i = chance(50);
         step(e, o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset outputs cycle %0d: dut=%h expected=%h", i, o, e);
         end
      end
      reset_n_i = 1'b1; start_i = 1'b0;
   endtask

   task automatic check_job(input string name, input int cycles, input int dones,
                            input int want_cycles, input int want_dones);
      n_checks++;
      if (dones !== want_dones) begin
         n_fail++;
         $display("FAIL %s done count: got %0d, required %0d", name, dones, want_dones);
      end
      if (want_cycles >= 0) begin
         n_checks++;
         if (cycles !== want_cycles) begin
            n_fail++;
            $display("FAIL %s job length: got %0d, required %0d", name, cycles, want_cycles);
         end
      end
   endtask

   task automatic test_nominal();
      int c, d;
      run_job("nominal", 1'b1, 100, 100, 100, 100, -1, 0, -1, 0, -1, 1'b0, c, d);
      check_job("nominal", c, d, 1 + NUM_OPS + CC + NUM_MACS, 1);
   endtask

   task automatic test_array_backpressure();
      int c, d;
      run_job("array_bp", 1'b1, 100, 100, 100, 100, 3, 5, -1, 0, -1, 1'b0, c, d);
      check_job("array_bp", c, d, 1 + NUM_OPS + CC + NUM_MACS + 5, 1);
   endtask

   task automatic test_fifo_full();
      int c, d;
      run_job("fifo_full", 1'b1, 100, 100, 100, 100, -1, 0, 1, 6, -1, 1'b0, c, d);
      check_job("fifo_full", c, d, 1 + NUM_OPS + CC + NUM_MACS + 6, 1);
   endtask

   task automatic test_abort();
      int c, d;
      run_job("abort", 1'b1, 100, 100, 100, 100, -1, 0, -1, 0, 3, 1'b0, c, d);
      check_job("abort", c, d, -1, 0);
      run_job("after_abort", 1'b1, 100, 100, 100, 100, -1, 0, -1, 0, -1, 1'b0, c, d);
      check_job("after_abort", c, d, 1 + NUM_OPS + CC + NUM_MACS, 1);
   endtask

   task automatic test_back_to_back();
      int c, d;
      run_job("b2b_first", 1'b0, 100, 100, 100, 100, -1, 0, -1, 0, -1, 1'b1, c, d);
      check_job("b2b_first", c, d, 1 + NUM_OPS + CC + NUM_MACS, 1);
      run_job("b2b_second", 1'b0, 100, 100, 100, 100, -1, 0, -1, 0, -1, 1'b0, c, d);
      check_job("b2b_second", c, d, 1 + NUM_OPS + CC + NUM_MACS, 1);
   endtask

   task automatic test_random();
      int c, d;
      for (int j = 0; j < 6; j++) begin
         run_job($sformatf("random%0d", j), 1'b0, 60, 70, 60, 70, -1, 0, -1, 0, -1, 1'b0, c, d);
         check_job($sformatf("random%0d", j), c, d, -1, 1);
      end
   endtask

   initial begin
      reset_n_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; data_i = '0;
      array_ready_i = 1'b0; array_valid_i = 1'b0; array_data_i = '0; fifo_ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      test_reset();
      test_nominal();
      test_array_backpressure();
      test_fifo_full();
      test_abort();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
